// File: rtl/full_pkg.sv
// Shared types and defaults for the one-bit full adder.
package full_pkg;

    // Two-bit {carry, sum} result of adding three single bits.
    typedef logic [1:0] sum2_t;

    localparam int REG_OUT_DEFAULT = 1;

endpackage

// File: rtl/full_half_adder.sv
// Half adder: sum = x ^ y, carry = x & y.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule

// File: rtl/full.sv
// One-bit full adder with an optional registered result stage.
// Defining FULL_SELF_CHECK_EN adds a sticky err output that flags arithmetic mismatches.
module full
    import full_pkg::*;
#(
    parameter int REG_OUT = REG_OUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic in_valid,
    output logic s,
    output logic cout,
    output logic s_q,
    output logic cout_q,
    output logic out_valid
`ifdef FULL_SELF_CHECK_EN
    ,
    output logic err
`endif
);

    logic p;
    logic g1;
    logic g2;

    half_adder ha1 (
        .x    (a),
        .y    (b),
        .sum  (p),
        .carry(g1)
    );

    half_adder ha2 (
        .x    (p),
        .y    (cin),
        .sum  (s),
        .carry(g2)
    );

    // Both half-adder carries can never be high together, so OR is enough.
    assign cout = g1 | g2;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic s_reg;
            logic cout_reg;
            logic valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_reg     <= 1'b0;
                    cout_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= in_valid;
                    if (in_valid) begin
                        s_reg    <= s;
                        cout_reg <= cout;
                    end
                end
            end

            assign s_q       = s_reg;
            assign cout_q    = cout_reg;
            assign out_valid = valid_reg;
        end else begin : g_noreg
            assign s_q       = 1'b0;
            assign cout_q    = 1'b0;
            assign out_valid = 1'b0;
        end
    endgenerate

`ifdef FULL_SELF_CHECK_EN
    // Independent arithmetic reference compared against the gate-level result.
    sum2_t expected_sum;
    logic  err_reg;

    always_comb begin
        expected_sum = sum2_t'({1'b0, a} + {1'b0, b} + {1'b0, cin});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (in_valid && ({cout, s} != expected_sum)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_full.sv
// Self-checking bench for full: exhaustive combinational sweep, directed registered-path steps, then random steps.
module tb_full;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic in_valid;
    logic s;
    logic cout;
    logic s_q;
    logic cout_q;
    logic out_valid;
`ifdef FULL_SELF_CHECK_EN
    logic err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: the last accepted sum and whether a fresh one is pending.
    logic [1:0] m_result;
    logic       m_fresh;

    always #5 clk = ~clk;

    full #(
        .REG_OUT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .in_valid (in_valid),
        .s        (s),
        .cout     (cout),
        .s_q      (s_q),
        .cout_q   (cout_q),
        .out_valid(out_valid)
`ifdef FULL_SELF_CHECK_EN
        ,
        .err      (err)
`endif
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check comb, clock, check registered outputs.
    task automatic step(input string tag, input logic r, input logic iv,
                        input logic x, input logic y, input logic z);
        int total;
        total    = x + y + z;
        rst      = r;
        in_valid = iv;
        a        = x;
        b        = y;
        cin      = z;
        #1;
        chk({tag, "_comb"}, {cout, s}, total[1:0]);
        @(posedge clk);
        if (r) begin
            m_result = 2'b00;
            m_fresh  = 1'b0;
        end else begin
            m_fresh = iv;
            if (iv) m_result = total[1:0];
        end
        @(negedge clk);
        chk({tag, "_reg"}, {cout_q, s_q}, m_result);
        chk({tag, "_ov"}, {1'b0, out_valid}, {1'b0, m_fresh});
`ifdef FULL_SELF_CHECK_EN
        chk({tag, "_err"}, {1'b0, err}, 2'b00);
`endif
        $display("step %s rst=%0b iv=%0b abc=%0b%0b%0b -> s=%0b cout=%0b s_q=%0b cout_q=%0b ov=%0b",
                 tag, r, iv, x, y, z, s, cout, s_q, cout_q, out_valid);
    endtask

    initial begin
        logic [2:0] v;
        m_result = 2'b00;
        m_fresh  = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        cin      = 1'b0;

        // Exhaustive combinational sweep, one time unit per vector.
        for (int i = 0; i < 8; i++) begin
            v   = 3'(i);
            a   = v[2];
            b   = v[1];
            cin = v[0];
            #1;
            chk($sformatf("sweep_%0d", i), {cout, s}, 2'(v[2] + v[1] + v[0]));
            $display("sweep abc=%03b -> cout,s=%0b%0b", v, cout, s);
        end

        @(negedge clk);
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("capture110", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("hold111", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("after_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("b2b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef FULL_SELF_CHECK_EN
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step($sformatf("chk_sweep_%0d", i), 1'b0, 1'b1, v[2], v[1], v[0]);
        end
        step("chk_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 200; i++) begin
            step($sformatf("rand_%0d", i),
                 ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
